// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and shared-memory signals around mem_port_arbiter.
//
// Fetch side : i_req, i_addr in; i_rdata, i_ack, i_err out of the arbiter.
// Data side  : d_req, d_we, d_addr, d_wdata, d_wmask in; d_rdata, d_ack, d_err out.
// Memory side: m_req, m_we, m_addr, m_wdata, m_wmask out; m_rdata, m_ack in.
//
// slave  : the arbiter's view (serves the requesters, drives the memory bus).
// master : the surrounding system's view (requesters plus memory).
interface mem_port_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic [31:0] i_rdata;
    logic        i_ack;
    logic        i_err;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [3:0]  d_wmask;
    logic [31:0] d_rdata;
    logic        d_ack;
    logic        d_err;

    logic        m_req;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic [3:0]  m_wmask;
    logic [31:0] m_rdata;
    logic        m_ack;

    modport slave (
        input  i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wmask, m_rdata, m_ack,
        output i_rdata, i_ack, i_err, d_rdata, d_ack, d_err,
        output m_req, m_we, m_addr, m_wdata, m_wmask
    );

    modport master (
        output i_req, i_addr, d_req, d_we, d_addr, d_wdata, d_wmask, m_rdata, m_ack,
        input  i_rdata, i_ack, i_err, d_rdata, d_ack, d_err,
        input  m_req, m_we, m_addr, m_wdata, m_wmask
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter (instruction fetch, data load/store) for one shared memory port.
// One access is outstanding at a time; ties alternate via a last-grant pointer, and an
// access that waits TIMEOUT cycles for m_ack is aborted with an err pulse.
//
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset
//   bus  - mem_port_arbiter_if.slave: fetch, data and shared-memory signal groups
// Parameter:
//   TIMEOUT - bus cycles a granted access may wait for m_ack (1..255)
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 16
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StBusyI, StBusyD} state_e;

    localparam logic [7:0] CountLast = 8'(TIMEOUT - 1);
    localparam logic       GrantI    = 1'b0;
    localparam logic       GrantD    = 1'b1;

    state_e      state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [7:0]  count_q, count_d;
    logic        m_we_q, m_we_d;
    logic [31:0] m_addr_q, m_addr_d;
    logic [31:0] m_wdata_q, m_wdata_d;
    logic [3:0]  m_wmask_q, m_wmask_d;
    logic        i_ack_q, i_ack_d, i_err_q, i_err_d;
    logic        d_ack_q, d_ack_d, d_err_q, d_err_d;
    logic [31:0] i_rdata_q, i_rdata_d, d_rdata_q, d_rdata_d;

    // A requester whose completion pulse is showing this cycle is still holding its
    // finished request; it must not be granted again on it.
    logic i_elig, d_elig, pick_d;
    assign i_elig = bus.i_req && !i_ack_q && !i_err_q;
    assign d_elig = bus.d_req && !d_ack_q && !d_err_q;
    assign pick_d = d_elig && (!i_elig || (last_grant_q == GrantI));

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        count_d      = count_q;
        m_we_d       = m_we_q;
        m_addr_d     = m_addr_q;
        m_wdata_d    = m_wdata_q;
        m_wmask_d    = m_wmask_q;
        i_ack_d      = 1'b0;
        i_err_d      = 1'b0;
        d_ack_d      = 1'b0;
        d_err_d      = 1'b0;
        i_rdata_d    = i_rdata_q;
        d_rdata_d    = d_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (pick_d) begin
                    state_d      = StBusyD;
                    last_grant_d = GrantD;
                    count_d      = 8'd0;
                    m_we_d       = bus.d_we;
                    m_addr_d     = bus.d_addr;
                    m_wdata_d    = bus.d_wdata;
                    m_wmask_d    = bus.d_we ? bus.d_wmask : 4'b0000;
                end else if (i_elig) begin
                    state_d      = StBusyI;
                    last_grant_d = GrantI;
                    count_d      = 8'd0;
                    m_we_d       = 1'b0;
                    m_addr_d     = bus.i_addr;
                    m_wdata_d    = 32'd0;
                    m_wmask_d    = 4'b0000;
                end
            end
            StBusyI, StBusyD: begin
                // m_ack is checked first so it beats a timeout in the same cycle.
                if (bus.m_ack) begin
                    state_d = StIdle;
                    if (state_q == StBusyI) begin
                        i_ack_d   = 1'b1;
                        i_rdata_d = bus.m_rdata;
                    end else begin
                        d_ack_d   = 1'b1;
                        d_rdata_d = m_we_q ? 32'd0 : bus.m_rdata;
                    end
                end else if (count_q == CountLast) begin
                    state_d = StIdle;
                    if (state_q == StBusyI) begin
                        i_err_d   = 1'b1;
                        i_rdata_d = 32'd0;
                    end else begin
                        d_err_d   = 1'b1;
                        d_rdata_d = 32'd0;
                    end
                end else begin
                    count_d = count_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            last_grant_q <= GrantI;
            count_q      <= 8'd0;
            m_we_q       <= 1'b0;
            m_addr_q     <= 32'd0;
            m_wdata_q    <= 32'd0;
            m_wmask_q    <= 4'b0000;
            i_ack_q      <= 1'b0;
            i_err_q      <= 1'b0;
            d_ack_q      <= 1'b0;
            d_err_q      <= 1'b0;
            i_rdata_q    <= 32'd0;
            d_rdata_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            count_q      <= count_d;
            m_we_q       <= m_we_d;
            m_addr_q     <= m_addr_d;
            m_wdata_q    <= m_wdata_d;
            m_wmask_q    <= m_wmask_d;
            i_ack_q      <= i_ack_d;
            i_err_q      <= i_err_d;
            d_ack_q      <= d_ack_d;
            d_err_q      <= d_err_d;
            i_rdata_q    <= i_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    // m_req decodes straight from the registered state, so it is glitch-free.
    assign bus.m_req   = (state_q != StIdle);
    assign bus.m_we    = m_we_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.m_wmask = m_wmask_q;
    assign bus.i_ack   = i_ack_q;
    assign bus.i_err   = i_err_q;
    assign bus.i_rdata = i_rdata_q;
    assign bus.d_ack   = d_ack_q;
    assign bus.d_err   = d_err_q;
    assign bus.d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter (TIMEOUT=4): a transaction-level model updated
// on each rising edge, a per-cycle compare on the falling edge, and directed scenarios
// with literal expectations.
module tb_mem_port_arbiter;

    localparam int unsigned TIMEOUT = 4;

    logic clk;
    logic rst;
    mem_port_arbiter_if bus ();

    mem_port_arbiter #(.TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    // ---------------- model ----------------
    int          owner;       // 0: bus free, 1: fetch owns the bus, 2: data owns it
    int          waited;      // ack-less cycles the owner has spent on the bus
    bit          data_first;  // who wins the next tie
    bit          model_live = 1'b0;
    logic [31:0] x_addr, x_wdata, x_i_rdata, x_d_rdata;
    logic        x_we, x_i_ack, x_i_err, x_d_ack, x_d_err;
    logic [3:0]  x_wmask;

    task automatic model_step();
        bit i_ok, d_ok;
        if (rst) begin
            owner = 0; waited = 0; data_first = 1'b1; model_live = 1'b1;
            x_addr = '0; x_wdata = '0; x_we = 1'b0; x_wmask = '0;
            x_i_ack = 1'b0; x_i_err = 1'b0; x_d_ack = 1'b0; x_d_err = 1'b0;
            x_i_rdata = '0; x_d_rdata = '0;
            return;
        end
        i_ok = bus.i_req && !x_i_ack && !x_i_err;
        d_ok = bus.d_req && !x_d_ack && !x_d_err;
        x_i_ack = 1'b0; x_i_err = 1'b0; x_d_ack = 1'b0; x_d_err = 1'b0;
        if (owner == 0) begin
            waited = 0;
            if (d_ok && (!i_ok || data_first)) begin
                owner = 2; data_first = 1'b0;
                x_addr = bus.d_addr; x_we = bus.d_we; x_wdata = bus.d_wdata;
                x_wmask = bus.d_we ? bus.d_wmask : 4'b0000;
            end else if (i_ok) begin
                owner = 1; data_first = 1'b1;
                x_addr = bus.i_addr; x_we = 1'b0; x_wdata = '0; x_wmask = '0;
            end
        end else if (bus.m_ack) begin
            if (owner == 1) begin
                x_i_ack = 1'b1; x_i_rdata = bus.m_rdata;
            end else begin
                x_d_ack = 1'b1; x_d_rdata = x_we ? 32'd0 : bus.m_rdata;
            end
            owner = 0;
        end else if (waited + 1 >= int'(TIMEOUT)) begin
            if (owner == 1) begin
                x_i_err = 1'b1; x_i_rdata = '0;
            end else begin
                x_d_err = 1'b1; x_d_rdata = '0;
            end
            owner = 0;
        end else begin
            waited++;
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (model_live) begin
            check("m_req", 32'(bus.m_req), 32'(owner != 0));
            if (owner != 0) begin
                check("m_addr", bus.m_addr, x_addr);
                check("m_we", 32'(bus.m_we), 32'(x_we));
                check("m_wmask", 32'(bus.m_wmask), 32'(x_wmask));
                if (owner == 1 || x_we) check("m_wdata", bus.m_wdata, x_wdata);
            end else if (!bus.m_we) begin
                check("m_wmask_idle", 32'(bus.m_wmask), 32'd0);
            end
            check("i_ack", 32'(bus.i_ack), 32'(x_i_ack));
            check("i_err", 32'(bus.i_err), 32'(x_i_err));
            check("d_ack", 32'(bus.d_ack), 32'(x_d_ack));
            check("d_err", 32'(bus.d_err), 32'(x_d_err));
            check("i_rdata", bus.i_rdata, x_i_rdata);
            check("d_rdata", bus.d_rdata, x_d_rdata);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) @(negedge clk);
    endtask

    int got[6];
    int want[6] = '{2, 1, 2, 1, 2, 1};
    int n_grants, n_done, idle, busy;
    logic prev_req;

    initial begin
        rst = 1'b1;
        bus.i_req = 1'b0; bus.i_addr = '0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_wmask = '0;
        bus.m_rdata = '0; bus.m_ack = 1'b0;
        cyc(3);
        check("rst_m_req", 32'(bus.m_req), 32'd0);
        check("rst_m_addr", bus.m_addr, 32'd0);
        check("rst_rdata", bus.i_rdata | bus.d_rdata, 32'd0);
        rst = 1'b0;
        cyc(1);

        // Tie after reset: data first, then fetch.
        bus.i_req = 1'b1; bus.i_addr = 32'h0000_0100;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_2000;
        cyc(1);                                   // cycle 1
        check("tie_m_req", 32'(bus.m_req), 32'd1);
        check("tie_m_addr", bus.m_addr, 32'h0000_2000);
        check("tie_m_we", 32'(bus.m_we), 32'd0);
        bus.m_ack = 1'b1; bus.m_rdata = 32'h1111_2222;
        cyc(1);                                   // cycle 2
        bus.m_ack = 1'b0;
        check("tie_d_ack", 32'(bus.d_ack), 32'd1);
        check("tie_d_rdata", bus.d_rdata, 32'h1111_2222);
        bus.d_req = 1'b0;
        cyc(1);                                   // cycle 3
        check("tie_next_is_fetch", bus.m_addr, 32'h0000_0100);
        bus.m_ack = 1'b1; bus.m_rdata = 32'hCAFE_0001;
        cyc(1);
        bus.m_ack = 1'b0;
        check("tie_i_rdata", bus.i_rdata, 32'hCAFE_0001);
        bus.i_req = 1'b0;
        cyc(2);

        // Fetch only, memory answers in cycle 1.
        bus.i_req = 1'b1; bus.i_addr = 32'h0000_0010;
        cyc(1);
        check("f_m_addr", bus.m_addr, 32'h0000_0010);
        check("f_m_wdata", bus.m_wdata, 32'd0);
        bus.m_ack = 1'b1; bus.m_rdata = 32'h0050_0093;
        cyc(1);
        bus.m_ack = 1'b0;
        check("f_i_ack", 32'(bus.i_ack), 32'd1);
        check("f_i_rdata", bus.i_rdata, 32'h0050_0093);
        check("f_d_ack", 32'(bus.d_ack), 32'd0);
        bus.i_req = 1'b0;
        cyc(1);
        check("f_ack_one_cycle", 32'(bus.i_ack), 32'd0);
        cyc(1);

        // Store, memory answers in cycle 3; store data returns 0.
        bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 32'h1000_0004;
        bus.d_wmask = 4'b1100; bus.d_wdata = 32'hAABB_CCDD;
        for (int c = 1; c <= 3; c++) begin
            cyc(1);
            check("s_m_addr", bus.m_addr, 32'h1000_0004);
            check("s_m_wmask", 32'(bus.m_wmask), 32'h0000_000C);
            check("s_m_wdata", bus.m_wdata, 32'hAABB_CCDD);
        end
        bus.m_ack = 1'b1; bus.m_rdata = 32'hDEAD_BEEF;
        cyc(1);                                   // cycle 4
        bus.m_ack = 1'b0;
        check("s_d_ack", 32'(bus.d_ack), 32'd1);
        check("s_d_rdata", bus.d_rdata, 32'd0);
        check("s_i_rdata_held", bus.i_rdata, 32'h0050_0093);
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_wmask = '0;
        cyc(2);

        // Load to give d_rdata a nonzero value.
        bus.d_req = 1'b1; bus.d_addr = 32'h0000_0020;
        cyc(1);
        bus.m_ack = 1'b1; bus.m_rdata = 32'h55AA_55AA;
        cyc(1);
        bus.m_ack = 1'b0;
        check("l_d_rdata", bus.d_rdata, 32'h55AA_55AA);
        bus.d_req = 1'b0;
        cyc(2);

        // Load that never sees m_ack: err at cycle 5, late ack at cycle 6 ignored.
        bus.d_req = 1'b1; bus.d_addr = 32'h0000_0030;
        for (int c = 1; c <= 4; c++) begin
            cyc(1);
            check("to_m_req", 32'(bus.m_req), 32'd1);
        end
        cyc(1);                                   // cycle 5
        check("to_d_err", 32'(bus.d_err), 32'd1);
        check("to_d_rdata", bus.d_rdata, 32'd0);
        check("to_m_req_low", 32'(bus.m_req), 32'd0);
        bus.d_req = 1'b0;
        cyc(1);                                   // cycle 6
        bus.m_ack = 1'b1; bus.m_rdata = 32'h0BAD_0BAD;
        cyc(1);                                   // cycle 7
        bus.m_ack = 1'b0;
        check("late_ack_ignored", 32'({bus.d_ack, bus.d_err, bus.i_ack, bus.i_err}), 32'd0);
        check("late_rdata", bus.d_rdata, 32'd0);
        cyc(1);

        // m_ack in the timeout cycle wins.
        bus.d_req = 1'b1; bus.d_addr = 32'h0000_0034;
        cyc(4);                                   // cycle 4
        bus.m_ack = 1'b1; bus.m_rdata = 32'h1234_5678;
        cyc(1);
        bus.m_ack = 1'b0;
        check("race_d_ack", 32'(bus.d_ack), 32'd1);
        check("race_d_err", 32'(bus.d_err), 32'd0);
        check("race_d_rdata", bus.d_rdata, 32'h1234_5678);
        bus.d_req = 1'b0;
        cyc(2);

        // Reset in the middle of a fetch.
        bus.i_req = 1'b1; bus.i_addr = 32'h0000_0040;
        cyc(2);                                   // cycle 2
        rst = 1'b1;
        cyc(1);                                   // cycle 3
        rst = 1'b0;
        bus.i_req = 1'b0;
        check("mr_m_req", 32'(bus.m_req), 32'd0);
        check("mr_m_addr", bus.m_addr, 32'd0);
        check("mr_rdata", bus.i_rdata | bus.d_rdata, 32'd0);
        check("mr_pulses", 32'({bus.d_ack, bus.d_err, bus.i_ack, bus.i_err}), 32'd0);
        cyc(1);                                   // cycle 4
        bus.m_ack = 1'b1; bus.m_rdata = 32'h0000_0099;
        cyc(1);
        bus.m_ack = 1'b0;
        check("mr_ack_ignored", 32'(bus.i_ack), 32'd0);
        bus.d_req = 1'b1; bus.d_addr = 32'h0000_0050;
        cyc(1);
        check("mr_new_grant", bus.m_addr, 32'h0000_0050);
        bus.m_ack = 1'b1; bus.m_rdata = 32'h0000_0077;
        cyc(1);
        bus.m_ack = 1'b0;
        check("mr_new_d_rdata", bus.d_rdata, 32'h0000_0077);
        bus.d_req = 1'b0;
        cyc(2);

        // Both requesters held continuously after reset: D,I,D,I,D,I.
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        bus.i_req = 1'b1; bus.i_addr = 32'h0000_1000;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h0000_2000;
        n_grants = 0; n_done = 0; idle = 0; busy = 0; prev_req = 1'b0;
        for (int c = 0; c < 80 && n_done < 6; c++) begin
            cyc(1);
            if (bus.i_ack || bus.d_ack || bus.i_err || bus.d_err) n_done++;
            if (bus.m_req && !prev_req && n_grants < 6) begin
                got[n_grants] = (bus.m_addr == 32'h0000_2000) ? 2 : 1;
                n_grants++;
            end
            if (!bus.m_req && n_grants > 0) idle++;
            prev_req = bus.m_req;
            bus.m_ack = 1'b0;
            if (bus.m_req) begin
                busy++;
                if (busy == 1 + (n_grants % 3)) begin
                    bus.m_ack = 1'b1; bus.m_rdata = 32'hA000_0000 + 32'(n_grants); busy = 0;
                end
            end
        end
        bus.i_req = 1'b0; bus.d_req = 1'b0; bus.m_ack = 1'b0;
        check("alt_done", 32'(n_done), 32'd6);
        check("alt_grants", 32'(n_grants), 32'd6);
        for (int k = 0; k < 6; k++) check("alt_order", 32'(got[k]), 32'(want[k]));
        check("alt_idle_cycles", 32'(idle), 32'd6);
        cyc(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
